// File: rtl/axi4_m_r_req_split_pkg.sv
// Shared definitions for the read side of the AXI4 bridge: protocol constants,
// the request-splitter state encoding and the AxSIZE helper.
package axi4_bridge_pkg;

    localparam int         AXI_4K         = 4096;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_ISSUE = 2'd1,
        RS_WAIT  = 2'd2
    } rs_state_e;

    // AxSIZE encoding for a beat of stbw bytes.
    function automatic logic [2:0] size_of(input int stbw);
        return 3'($clog2(stbw));
    endfunction

endpackage

// File: rtl/axi4_m_r_req_split_if.sv
// Command and request bundle between the host command source, the splitter and
// the AXI4 read master. The master view is the host / read-master side; the
// slave view is the splitter itself.
interface axi4_m_r_req_split_if #(
    parameter int ADRW = 32,
    parameter int BYTW = 13
);
    logic [ADRW-1:0] cmd_addr;
    logic [BYTW-1:0] cmd_bytes;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ADRW-1:0] req_addr;
    logic [7:0]      req_len;
    logic [2:0]      req_size;
    logic            req_valid;
    logic            i_done;

    modport master (
        output cmd_addr, cmd_bytes, cmd_valid, i_done,
        input  cmd_ready, req_addr, req_len, req_size, req_valid
    );

    modport slave (
        input  cmd_addr, cmd_bytes, cmd_valid, i_done,
        output cmd_ready, req_addr, req_len, req_size, req_valid
    );
endinterface

// File: rtl/axi4_m_r_req_split_fifo.sv
// Small synchronous command FIFO holding {address, byte count} entries.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module axi4_rd_cmd_fifo #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset flushes the queue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/axi4_m_r_req_split.sv
// Read command splitter: queues host read commands and turns each into a
// sequence of INCR bursts that never cross a 4 KB page and never exceed
// MAX_BEATS, handing one burst at a time to the AXI4 read master and waiting
// for its last R beat before issuing the next.
module axi4_m_r_req_split
    import axi4_bridge_pkg::*;
#(
    parameter int ADRW      = 32,
    parameter int DATW      = 256,
    parameter int BYTW      = 13,
    parameter int MAX_BEATS = 256,
    parameter int DEPTH     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    axi4_m_r_req_split_if.slave  bus,
    output logic                 o_busy,
    output logic                 o_err_done
);
    localparam int STBW = DATW / 8;
    localparam int SZ   = $clog2(STBW);
    // Wide enough for a rounded-up byte count and for a full page of beats.
    localparam int NW   = (BYTW + 1 > 14) ? BYTW + 1 : 14;

    rs_state_e state_q, state_d;

    logic [ADRW-1:0] cur_addr_q, cur_addr_d;
    logic [NW-1:0]   rem_q, rem_d;
    logic [ADRW-1:0] req_addr_q, req_addr_d;
    logic [7:0]      req_len_q, req_len_d;
    logic            req_valid_q, req_valid_d;
    logic            err_q, err_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ADRW+BYTW-1:0] fifo_rdata;
    logic [ADRW-1:0]      fifo_addr;
    logic [BYTW-1:0]      fifo_bytes;
    logic                 cmd_ready;

    logic [NW-1:0] pop_beats;
    logic [NW-1:0] page_room;
    logic [NW-1:0] burst_n;

    function automatic logic [NW-1:0] min3(input logic [NW-1:0] a,
                                           input logic [NW-1:0] b,
                                           input logic [NW-1:0] c);
        logic [NW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Ready is held low while reset is asserted, independent of FIFO state.
    assign cmd_ready  = !fifo_full && !i_rst;
    assign fifo_push  = bus.cmd_valid && cmd_ready;
    assign fifo_addr  = fifo_rdata[ADRW+BYTW-1:BYTW];
    assign fifo_bytes = fifo_rdata[BYTW-1:0];

    axi4_rd_cmd_fifo #(
        .WIDTH (ADRW + BYTW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push_i  (fifo_push),
        .wdata_i ({bus.cmd_addr, bus.cmd_bytes}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Burst sizing: rounded-up beat count at load, then the page/length limits.
    assign pop_beats = (NW'(fifo_bytes) + NW'(STBW - 1)) >> SZ;
    assign page_room = (NW'(AXI_4K) - NW'(cur_addr_q[11:0])) >> SZ;
    assign burst_n   = min3(rem_q, page_room, NW'(MAX_BEATS));

    assign bus.cmd_ready = cmd_ready;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_len   = req_len_q;
    assign bus.req_size  = size_of(STBW);
    assign bus.req_valid = req_valid_q;
    assign o_busy        = (state_q != RS_IDLE) || !fifo_empty;
    assign o_err_done    = err_q;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= RS_IDLE;
        else       state_q <= state_d;
    end

    // Next state, FIFO pop and the working/request register updates.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        req_valid_d = 1'b0;
        fifo_pop    = 1'b0;
        // A completion outside WAIT has no burst to belong to; remember it.
        err_d       = err_q | (bus.i_done && (state_q != RS_WAIT));

        case (state_q)
            RS_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_addr_d = fifo_addr & ~ADRW'(STBW - 1);
                    rem_d      = pop_beats;
                    // Zero-length commands are consumed without a request.
                    if (pop_beats != '0) state_d = RS_ISSUE;
                end
            end
            RS_ISSUE: begin
                req_addr_d  = cur_addr_q;
                req_len_d   = 8'(burst_n - NW'(1));
                req_valid_d = 1'b1;
                cur_addr_d  = cur_addr_q + (ADRW'(burst_n) << SZ);
                rem_d       = rem_q - burst_n;
                state_d     = RS_WAIT;
            end
            RS_WAIT: begin
                if (bus.i_done) state_d = (rem_q != '0) ? RS_ISSUE : RS_IDLE;
            end
            default: state_d = RS_IDLE;
        endcase
    end

    // Working address/count, registered request outputs and the sticky error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur_addr_q  <= '0;
            rem_q       <= '0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            req_valid_q <= req_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_axi4_m_r_req_split.sv
// Bench for axi4_m_r_req_split with DATW=256 (32-byte beats) and MAX_BEATS=16.
module tb_axi4_m_r_req_split;
    localparam int ADRW  = 32;
    localparam int DATW  = 256;
    localparam int BYTW  = 13;
    localparam int MAXB  = 16;
    localparam int DEPTH = 4;
    localparam int STBW  = DATW / 8;

    logic i_clk = 1'b0;
    logic i_rst;
    logic o_busy;
    logic o_err_done;

    axi4_m_r_req_split_if #(.ADRW(ADRW), .BYTW(BYTW)) bus();

    axi4_m_r_req_split #(
        .ADRW(ADRW), .DATW(DATW), .BYTW(BYTW), .MAX_BEATS(MAXB), .DEPTH(DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .bus        (bus),
        .o_busy     (o_busy),
        .o_err_done (o_err_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int served = 0;

    int unsigned obs_addr[$];
    int          obs_len[$];
    int          obs_cyc[$];
    int          done_cyc[$];
    int unsigned exp_addr[$];
    int          exp_len[$];
    int          exp_gap[$];

    // One clock: advance past the edge and log any request pulse seen.
    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
        if (!i_rst && bus.req_valid === 1'b1) begin
            obs_addr.push_back(bus.req_addr);
            obs_len.push_back(int'(bus.req_len));
            obs_cyc.push_back(cyc);
        end
    endtask

    task automatic clear();
        obs_addr.delete(); obs_len.delete(); obs_cyc.delete(); done_cyc.delete();
        exp_addr.delete(); exp_len.delete(); exp_gap.delete();
        served = 0;
    endtask

    // Reference: split one command into bursts by the page / length rules.
    task automatic model_cmd(input logic [31:0] addr, input int bytes, input int zeros);
        longint a;
        int beats, room, n;
        bit first;
        first = 1'b1;
        a = longint'(addr) & ~longint'(STBW - 1);
        beats = (bytes + STBW - 1) / STBW;
        while (beats > 0) begin
            room = (4096 - int'(a % 4096)) / STBW;
            n = beats;
            if (room < n) n = room;
            if (MAXB < n) n = MAXB;
            exp_addr.push_back(32'(a));
            exp_len.push_back(n - 1);
            exp_gap.push_back(first ? 2 + zeros : 1);
            first = 1'b0;
            a = (a + longint'(n) * STBW) & 64'hFFFF_FFFF;
            beats -= n;
        end
    endtask

    task automatic push_cmd(input logic [31:0] a, input int b, output bit ok);
        int t;
        bit acc;
        t = 0; acc = 1'b0;
        bus.cmd_addr = a; bus.cmd_bytes = 13'(b); bus.cmd_valid = 1'b1;
        while (!acc && t < 50) begin
            acc = (bus.cmd_ready === 1'b1);
            step();
            t++;
        end
        if (acc) acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        ok = acc;
    endtask

    // Answer the next n requests with a completion after a random delay.
    task automatic serve(input int n, input int maxd, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (obs_addr.size() <= served && t < 100) begin step(); t++; end
            if (obs_addr.size() <= served) begin ok = 1'b0; return; end
            repeat ($urandom_range(maxd, 0)) step();
            bus.i_done = 1'b1;
            step();
            bus.i_done = 1'b0;
            done_cyc.push_back(cyc);
            served++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step(); step();
        checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0h exp=0", bus.req_valid); end
        checks++; if (bus.req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr got=%0h exp=0", bus.req_addr); end
        checks++; if (bus.req_len !== 8'h0) begin failures++; $display("FAIL rst_req_len got=%0h exp=0", bus.req_len); end
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%0h exp=0", bus.cmd_ready); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", o_busy); end
        checks++; if (o_err_done !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", o_err_done); end
        checks++; if (bus.req_size !== 3'd5) begin failures++; $display("FAIL rst_req_size got=%0h exp=5", bus.req_size); end
        i_rst = 1'b0;
        step();
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL post_rst_cmd_ready got=%0h exp=1", bus.cmd_ready); end
    endtask

    task automatic test_single();
        bit ok;
        clear();
        push_cmd(32'h1000, 64, ok);
        repeat (4) step();
        checks++; if (!ok) begin failures++; $display("FAIL single_accept got=0 exp=1"); end
        checks++; if (obs_addr.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", obs_addr.size()); end
        if (obs_addr.size() > 0) begin
            checks++; if (obs_addr[0] != 32'h1000) begin failures++; $display("FAIL single_addr got=%0h exp=1000", obs_addr[0]); end
            checks++; if (obs_len[0] != 1) begin failures++; $display("FAIL single_len got=%0d exp=1", obs_len[0]); end
            checks++; if (obs_cyc[0] != acc_cyc + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", obs_cyc[0] - acc_cyc, 2); end
        end
        checks++; if (bus.req_addr !== 32'h1000 || bus.req_valid !== 1'b0) begin failures++; $display("FAIL single_hold got=%0h/%0h exp=1000/0", bus.req_addr, bus.req_valid); end
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy_wait got=%0h exp=1", o_busy); end
        serve(1, 0, ok);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%0h exp=0", o_busy); end
    endtask

    task automatic test_4k();
        bit ok;
        clear();
        push_cmd(32'h0FC0, 128, ok);
        serve(2, 2, ok);
        repeat (3) step();
        checks++; if (!ok || obs_addr.size() != 2) begin failures++; $display("FAIL page_count got=%0d exp=2", obs_addr.size()); end
        if (obs_addr.size() == 2) begin
            checks++; if (obs_addr[0] != 32'h0FC0 || obs_len[0] != 1) begin failures++; $display("FAIL page_first got=%0h/%0d exp=fc0/1", obs_addr[0], obs_len[0]); end
            checks++; if (obs_addr[1] != 32'h1000 || obs_len[1] != 1) begin failures++; $display("FAIL page_second got=%0h/%0d exp=1000/1", obs_addr[1], obs_len[1]); end
            checks++; if (obs_cyc[1] - done_cyc[0] != 1) begin failures++; $display("FAIL page_gap got=%0d exp=1", obs_cyc[1] - done_cyc[0]); end
        end
    endtask

    task automatic test_max_beats();
        bit ok;
        clear();
        push_cmd(32'h2000, 1024, ok);
        serve(2, 1, ok);
        repeat (4) step();
        checks++; if (!ok || obs_addr.size() != 2) begin failures++; $display("FAIL maxb_count got=%0d exp=2", obs_addr.size()); end
        if (obs_addr.size() == 2) begin
            checks++; if (obs_addr[0] != 32'h2000 || obs_len[0] != 15) begin failures++; $display("FAIL maxb_first got=%0h/%0d exp=2000/15", obs_addr[0], obs_len[0]); end
            checks++; if (obs_addr[1] != 32'h2200 || obs_len[1] != 15) begin failures++; $display("FAIL maxb_second got=%0h/%0d exp=2200/15", obs_addr[1], obs_len[1]); end
        end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL maxb_idle got=%0h exp=0", o_busy); end
    endtask

    task automatic test_round_zero();
        bit ok;
        clear();
        push_cmd(32'h3000, 40, ok);
        serve(1, 0, ok);
        repeat (2) step();
        checks++; if (!ok || obs_addr.size() != 1) begin failures++; $display("FAIL round_count got=%0d exp=1", obs_addr.size()); end
        if (obs_addr.size() == 1) begin
            checks++; if (obs_addr[0] != 32'h3000 || obs_len[0] != 1) begin failures++; $display("FAIL round_req got=%0h/%0d exp=3000/1", obs_addr[0], obs_len[0]); end
        end
        push_cmd(32'h3000, 0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL zero_accept got=0 exp=1"); end
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL zero_busy_queued got=%0h exp=1", o_busy); end
        repeat (5) step();
        checks++; if (obs_addr.size() != 1) begin failures++; $display("FAIL zero_no_req got=%0d exp=1", obs_addr.size()); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0h exp=0", o_busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear();
        bus.cmd_valid = 1'b1;
        bus.cmd_bytes = 13'd32;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_addr = 32'h5000 + 32'(i) * 32'h100;
            checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%0h exp=1", i, bus.cmd_ready); end
            step();
        end
        bus.cmd_addr = 32'h5500;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full%0d got=%0h exp=0", i, bus.cmd_ready); end
            step();
        end
        bus.i_done = 1'b1;
        step();
        bus.i_done = 1'b0;
        done_cyc.push_back(cyc);
        served = 1;
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_done_edge got=%0h exp=0", bus.cmd_ready); end
        step();
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_freed got=%0h exp=1", bus.cmd_ready); end
        step();
        bus.cmd_valid = 1'b0;
        serve(5, 2, ok);
        repeat (3) step();
        checks++; if (!ok || obs_addr.size() != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", obs_addr.size()); end
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != 32'h5000 + 32'(i) * 32'h100 || obs_len[i] != 0) begin
                failures++; $display("FAIL b2b_req%0d got=%0h/%0d exp=%0h/0", i, obs_addr[i], obs_len[i], 32'h5000 + 32'(i) * 32'h100);
            end
        end
    endtask

    task automatic test_err_done();
        bit ok;
        clear();
        checks++; if (o_err_done !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL err_pre got=%0h/%0h exp=0/0", o_err_done, o_busy); end
        bus.i_done = 1'b1;
        step();
        bus.i_done = 1'b0;
        repeat (3) step();
        checks++; if (obs_addr.size() != 0) begin failures++; $display("FAIL err_no_req got=%0d exp=0", obs_addr.size()); end
        checks++; if (o_err_done !== 1'b1) begin failures++; $display("FAIL err_set got=%0h exp=1", o_err_done); end
        push_cmd(32'h6000, 32, ok);
        serve(1, 1, ok);
        repeat (2) step();
        checks++; if (!ok || obs_addr.size() != 1) begin failures++; $display("FAIL err_req_count got=%0d exp=1", obs_addr.size()); end
        if (obs_addr.size() == 1) begin
            checks++; if (obs_addr[0] != 32'h6000 || obs_len[0] != 0) begin failures++; $display("FAIL err_req got=%0h/%0d exp=6000/0", obs_addr[0], obs_len[0]); end
        end
        checks++; if (o_err_done !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0h exp=1", o_err_done); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t;
        clear();
        for (int i = 0; i < 4; i++) begin
            push_cmd(32'h7000 + 32'(i) * 32'h100, 64, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rmid_accept%0d got=0 exp=1", i); end
        end
        t = 0;
        while (obs_addr.size() == 0 && t < 20) begin step(); t++; end
        checks++; if (obs_addr.size() != 1) begin failures++; $display("FAIL rmid_first got=%0d exp=1", obs_addr.size()); end
        i_rst = 1'b1;
        #1;
        checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0h exp=0", bus.req_valid); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0h exp=0", o_busy); end
        checks++; if (o_err_done !== 1'b0) begin failures++; $display("FAIL rmid_err got=%0h exp=0", o_err_done); end
        checks++; if (bus.req_addr !== 32'h0 || bus.req_len !== 8'h0) begin failures++; $display("FAIL rmid_req got=%0h/%0h exp=0/0", bus.req_addr, bus.req_len); end
        step();
        i_rst = 1'b0;
        repeat (4) step();
        checks++; if (obs_addr.size() != 1) begin failures++; $display("FAIL rmid_no_req got=%0d exp=1", obs_addr.size()); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rmid_flushed got=%0h exp=0", o_busy); end
        served = 1;
        push_cmd(32'h4000, 32, ok);
        repeat (4) step();
        checks++; if (obs_addr.size() != 2) begin failures++; $display("FAIL rmid_next_count got=%0d exp=2", obs_addr.size()); end
        if (obs_addr.size() == 2) begin
            checks++; if (obs_addr[1] != 32'h4000 || obs_len[1] != 0) begin failures++; $display("FAIL rmid_next got=%0h/%0d exp=4000/0", obs_addr[1], obs_len[1]); end
        end
        serve(1, 0, ok);
        step();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rmid_end_busy got=%0h exp=0", o_busy); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 20; b++) begin
            int nc, zeros, nexp, sel, by;
            bit ok;
            logic [31:0] a;
            clear();
            nc = $urandom_range(5, 1);
            zeros = 0;
            for (int c = 0; c < nc; c++) begin
                a = $urandom;
                sel = $urandom_range(9, 0);
                if (sel < 3) a = (a & ~32'hFFF) | (32'd4096 - 32'($urandom_range(8, 1)) * 32'd32);
                if (sel == 3) by = 0;
                else if (sel == 4) by = 4096;
                else by = $urandom_range(4096, 1);
                push_cmd(a, by, ok);
                checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_accept%0d got=0 exp=1", b, c); end
                model_cmd(a, by, zeros);
                if (by == 0) zeros++; else zeros = 0;
            end
            nexp = exp_addr.size();
            serve(nexp, 3, ok);
            repeat (3) step();
            checks++; if (!ok || obs_addr.size() != nexp) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", b, obs_addr.size(), nexp); end
            for (int i = 0; i < nexp && i < obs_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] != exp_addr[i] || obs_len[i] != exp_len[i]) begin
                    failures++; $display("FAIL rnd%0d_req%0d got=%0h/%0d exp=%0h/%0d", b, i, obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
                end
                if (i > 0 && i - 1 < done_cyc.size()) begin
                    checks++;
                    if (obs_cyc[i] - done_cyc[i-1] != exp_gap[i]) begin
                        failures++; $display("FAIL rnd%0d_gap%0d got=%0d exp=%0d", b, i, obs_cyc[i] - done_cyc[i-1], exp_gap[i]);
                    end
                end
            end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rnd%0d_idle got=%0h exp=0", b, o_busy); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_bytes = '0;
        bus.i_done = 1'b0;
        test_reset();
        test_single();
        test_4k();
        test_max_beats();
        test_round_zero();
        test_back_to_back();
        test_err_done();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_m_r_req_split.md
Name: axi4_m_r_req_split

Overview:
- Upstream command stage for the AXI4 read master (axi4_m_r) in the QEMU PCIe bridge.
- Queues host read commands (byte address plus byte count) and splits each into AXI-legal INCR bursts. Bursts never cross 4 KB and never exceed MAX_BEATS.
- Issues one req_addr/req_len/req_size/req_valid request to the read master at a time.
- Waits for that burst's completion (the last R beat) before issuing the next.

Parameters:
- ADRW, 32, address width.
- DATW, 256, AXI data width. Beat size STBW = DATW/8 bytes.
- BYTW, 13, width of the command byte count. Maximum count is 4096 (DTMP of the read master).
- MAX_BEATS, 256, burst beat limit (1..256).
- DEPTH, 4, command FIFO depth (power of 2, ≥2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- cmd_addr  in  ADRW  read start address; must be STBW-aligned.
- cmd_bytes  in  BYTW  byte count (0..4096).
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- req_addr  out  ADRW  burst address to the read master.
- req_len  out  8  AXI len (beats-1).
- req_size  out  3  constant $clog2(STBW).
- req_valid  out  1  one-cycle request pulse.
- i_done  in  1  completion strobe: R handshake with rlast (rvalid & rready & rlast).
- o_busy  out  1  engine not IDLE, or FIFO not empty.
- o_err_done  out  1  sticky: i_done seen while not in WAIT.

Behaviour:
- Reset (async, active-high):
  - FIFO flushed; state IDLE.
  - req_valid=0, req_addr=0, req_len=0, cmd_ready=0 while i_rst is high, o_busy=0, o_err_done=0.
  - req_size is constant $clog2(STBW).
  - Reset mid-burst abandons the command; no further requests are issued.
- cmd_ready = FIFO not full. A push when full is blocked even if a pop occurs in the same cycle.
- Low address bits [log2(STBW)-1:0] are forced to 0.
- Beats = ceil(cmd_bytes/STBW).
- Each burst: n = min(rem_beats, (4096 - addr[11:0])/STBW, MAX_BEATS).
  - req_len = n-1.
  - After issue: addr += n*STBW, rem_beats -= n.
- State machine:
  - IDLE:
    - FIFO not empty → pop, load cur_addr and rem_beats.
    - If beats==0 → stay IDLE; the command is discarded with no request.
    - Otherwise → ISSUE.
  - ISSUE (1 cycle):
    - Register req_addr and req_len.
    - req_valid=1 for exactly the next cycle (flopped output).
    - → WAIT.
  - WAIT:
    - i_done → ISSUE if rem_beats>0, else IDLE.
    - i_done cannot be used before req_valid has been seen by the read master. The 1-cycle gap matches the read master's return to IDLE on the edge after rlast.
- Latency:
  - Command accepted at edge E, with the engine IDLE and the FIFO empty.
  - Pop at E+1; req_valid high in the cycle after edge E+2.
  - Next burst's req_valid is high in the cycle after the second edge following i_done.
- req_addr and req_len are held stable between requests.
- i_done in IDLE/ISSUE: ignored for sequencing; sets o_err_done.
- cmd_bytes > 4096 is unsupported. Behaviour follows the arithmetic above, with no saturation.

Decomposition:
- Package axi4_bridge_pkg holds:
  - AXI_4K = 4096.
  - AXI_BURST_INCR = 2'b01.
  - Read-split state enum {RS_IDLE, RS_ISSUE, RS_WAIT}.
  - Function size_of(STBW).
- Sub-module axi4_rd_cmd_fifo: synchronous FIFO, width ADRW+BYTW, DEPTH entries, with full/empty flags, async active-high reset.

Test Plan (DATW=256, STBW=32, req_size=5):
- cmd 0x1000/64 → one req: addr 0x1000, len 1. After i_done, o_busy=0.
- cmd 0x0FC0/128 → req 0x0FC0 len 1; after i_done, req 0x1000 len 1. No request crosses 4 KB.
- MAX_BEATS=16, cmd 0x2000/1024 → req 0x2000 len 15; after i_done, req 0x2200 len 15; then IDLE.
- cmd 0x3000/40 → req len 1 (rounded up). cmd 0x3000/0 → accepted, no req_valid, o_busy drops.
- i_done held low, 6 cmds offered back-to-back → first popped into the engine, next 4 fill the FIFO, cmd_ready=0 for the 6th. It is accepted one cycle after the first i_done frees a slot.
- i_rst pulsed during WAIT with 3 queued → req_valid=0, o_busy=0, FIFO empty. Next cmd 0x4000/32 → req 0x4000 len 0.
- i_done pulsed in IDLE → no request, o_err_done=1 until reset.
